// File: rtl/axis_rptr_ctrl.sv
// Read-side pointer controller for the dual-clock AXI-Stream FIFO (rclk domain).
// Define AXIS_RPTR_CTRL_AEMPTY_EN to generate the almost_empty compare; otherwise it is tied 0.
module axis_rptr_ctrl #(
  parameter int PTR_WIDTH     = 3,
  parameter int DATA_WIDTH    = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    g_wptr_async,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic                  ram_rd_en,
  output logic [PTR_WIDTH-1:0]  ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [PTR_WIDTH:0]    usedw,
  output logic                  almost_empty
);

  localparam int PW = PTR_WIDTH + 1;
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]         sync_q [SS];
  logic [PW-1:0]         g_wptr_s;
  logic [PW-1:0]         b_wptr_s;
  logic [PW-1:0]         b_rptr;
  logic [PW-1:0]         b_rptr_inc;
  logic [PW-1:0]         b_pop;
  logic [PW-1:0]         usedw_d;
  logic                  mem_empty;
  logic                  pend;
  logic                  pop;
  logic [1:0]            occ;
  logic [1:0]            occ_d;
  logic [2:0]            demand;
  logic [2:0]            limit;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;

  // Write-pointer synchroniser; only the last stage is ever looked at.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SS; i++) begin
        sync_q[i] <= '0;
      end
      b_wptr_s <= '0;
    end else begin
      sync_q[0] <= g_wptr_async;
      for (int i = 1; i < SS; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      b_wptr_s <= gray2bin(g_wptr_s);
    end
  end

  assign g_wptr_s   = sync_q[SS-1];
  assign mem_empty  = (g_rptr == g_wptr_s);
  assign m_tvalid   = (occ != 2'd0);
  assign pop        = m_tvalid & m_tready;
  assign m_tdata    = head_q;
  assign ram_raddr  = b_rptr[PTR_WIDTH-1:0];
  assign b_rptr_inc = b_rptr + 1'b1;

  // Issue only if the word still in flight plus what stays buffered fits in two slots.
  assign demand    = {1'b0, occ} + {2'b00, pend};
  assign limit     = 3'd2 + {2'b00, pop};
  assign ram_rd_en = !mem_empty && (demand < limit);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr <= '0;
      g_rptr <= '0;
      pend   <= 1'b0;
    end else begin
      pend <= ram_rd_en;
      if (ram_rd_en) begin
        b_rptr <= b_rptr_inc;
        g_rptr <= bin2gray(b_rptr_inc);
      end
    end
  end

  // Two-entry output stage: the returning word lands behind whatever is still queued.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ;
    case (occ)
      2'd0: begin
        if (pend) begin
          head_d = ram_rdata;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (pend && pop) begin
          head_d = ram_rdata;
        end else if (pend) begin
          skid_d = ram_rdata;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = skid_q;
          if (pend) begin
            skid_d = ram_rdata;
          end else begin
            occ_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q <= '0;
      skid_q <= '0;
      occ    <= 2'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      occ    <= occ_d;
    end
  end

  assign usedw_d = b_wptr_s - b_pop;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_pop <= '0;
      usedw <= '0;
    end else begin
      usedw <= usedw_d;
      if (pop) begin
        b_pop <= b_pop + 1'b1;
      end
    end
  end

`ifdef AXIS_RPTR_CTRL_AEMPTY_EN
  localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

  // Built from the same next value as usedw so both flags move on one edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (usedw_d <= AE_T);
    end
  end
`else
  assign almost_empty = 1'b0;
`endif

endmodule
